frame_loader_sdram: RTL
=======================

FRAME_LOADER_SDRAM -- requirements
Module: frame_loader_sdram

Interface
REQ-001 The block SHALL have parameter H_ACTIVE, default 1024, meaning pixels per line (even).
REQ-002 The block SHALL have parameter V_ACTIVE, default 768, meaning lines per frame.
REQ-003 The block SHALL have parameter FRAME_ADDR_BITS, default 19, meaning the word-offset width; each frame slot is 2^FRAME_ADDR_BITS words.
REQ-004 The block SHALL have the port iCLK, input, 1 bit: the SDRAM-controller clock, the single clock of the block.
REQ-005 The block SHALL have the port iRST_N, input, 1 bit: synchronous active-low reset.
REQ-006 The block SHALL have the port iSTART, input, 1 bit: a one-cycle pulse that begins a frame load.
REQ-007 The block SHALL have the port iABORT, input, 1 bit: cancels a load in progress.
REQ-008 The block SHALL have the port iFRAME_ID, input, 6 bits: the destination frame slot.
REQ-009 The block SHALL have the port iPIX_DATA, input, 8 bits: one grey pixel from the SD-card reader.
REQ-010 The block SHALL have the port iPIX_VALID, input, 1 bit: iPIX_DATA is valid.
REQ-011 The block SHALL have the port oPIX_READY, output, 1 bit: the block accepts a pixel this cycle.
REQ-012 The block SHALL have the port iWAIT_REQUEST, input, 1 bit: SDRAM controller waitrequest.
REQ-013 The block SHALL have the port oWR_EN, output, 1 bit: SDRAM write request.
REQ-014 The block SHALL have the port oWR_ADDR, output, 25 bits: SDRAM word address.
REQ-015 The block SHALL have the port oWR_DATA, output, 16 bits: SDRAM write data.
REQ-016 The block SHALL have the port oBUSY, output, 1 bit: a load is in progress.
REQ-017 The block SHALL have the port oDONE, output, 1 bit: the last load completed; usable as the SDRAM address-mux select.

Function
REQ-018 The block SHALL implement states IDLE, FILL, WRITE and DONE.
REQ-019 In IDLE or DONE, iSTART=1 SHALL latch iFRAME_ID, clear the word counter, clear oDONE and enter FILL on the next cycle.
REQ-020 iSTART in FILL or WRITE SHALL be ignored.
REQ-021 oPIX_READY SHALL equal 1 only in FILL; a pixel is accepted when iPIX_VALID=1 and oPIX_READY=1.
REQ-022 The first accepted pixel of each pair SHALL be stored in oWR_DATA[7:0], and the second in oWR_DATA[15:8].
REQ-023 Acceptance of the second pixel SHALL move the block to WRITE, with oWR_EN=1 on the next cycle.
REQ-024 oWR_ADDR SHALL equal {frame_id_latched, word_count}, with word_count FRAME_ADDR_BITS bits wide and zero-extended to 25 bits.
REQ-025 In WRITE, oWR_EN, oWR_ADDR and oWR_DATA SHALL be held stable while iWAIT_REQUEST=1.
REQ-026 A write SHALL be accepted on the first cycle with oWR_EN=1 and iWAIT_REQUEST=0; on the following cycle oWR_EN SHALL be 0.
REQ-027 After an accepted write, word_count SHALL increment.
REQ-028 After an accepted write, the block SHALL go to DONE if the write was word (H_ACTIVE*V_ACTIVE/2)-1, and otherwise return to FILL.
REQ-029 oDONE SHALL be 1 only in DONE and SHALL hold until the next accepted iSTART or reset.
REQ-030 oBUSY SHALL be 1 in FILL and WRITE.
REQ-031 iABORT=1 in FILL or WRITE SHALL return the block to IDLE next cycle, drop oWR_EN, leave oDONE at 0 and discard any half-filled pair.
REQ-032 If iABORT and iSTART are both 1 in the same cycle, iABORT SHALL win.
REQ-033 The block SHALL not issue more than one write per three cycles, and SHALL not issue any write beyond the frame slot.

Reset
REQ-034 On iRST_N=0 at a rising edge, the block SHALL enter IDLE.
REQ-035 Under reset, oWR_EN, oPIX_READY, oBUSY and oDONE SHALL be 0, oWR_ADDR and oWR_DATA SHALL be 0, and word_count and the pixel-pair flag SHALL be 0.
REQ-036 Reset mid-write SHALL drop oWR_EN on the next cycle, even if iWAIT_REQUEST=1.

Configuration
REQ-037 With FRAME_LOADER_CHECKSUM_EN defined, the block SHALL add output oCHECKSUM, 16 bits: the modulo-2^16 sum of all accepted pixel bytes since the last accepted iSTART. oCHECKSUM SHALL be cleared by reset and by iSTART, and SHALL be frozen in DONE.
REQ-038 Without FRAME_LOADER_CHECKSUM_EN, the oCHECKSUM port and its logic SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-039 Bench case, small frame: H_ACTIVE=4, V_ACTIVE=2, iFRAME_ID=3, pixels 0x01..0x08 continuous, iWAIT_REQUEST=0 -> required: writes 0x0201 at 0x180000, 0x0403 at 0x180001, 0x0605 at 0x180002 and 0x0807 at 0x180003, then oDONE=1 and oBUSY=0.
REQ-040 Bench case, waitrequest hold: iWAIT_REQUEST=1 for 5 cycles on the first write -> required: oWR_EN, oWR_ADDR and oWR_DATA are unchanged for all 5 cycles, there is exactly one accepted write, and oPIX_READY=0 throughout.
REQ-041 Bench case, gapped input: iPIX_VALID toggles every cycle -> required: write data and addresses are the same as in REQ-039, with no duplicate or lost bytes.
REQ-042 Bench case, abort: iABORT is asserted after 3 pixels -> required: IDLE next cycle, oWR_EN=0, oDONE=0, and a new iSTART writes starting at offset 0 with a fresh pairing.
REQ-043 Bench case, start while busy: iSTART with iFRAME_ID=5 mid-load of frame 3 -> required: the start is ignored, and all addresses stay in the 0x18xxxx range.
REQ-044 Bench case, checksum (macro defined): pixels 0xFF x 8 -> required: oCHECKSUM = 0x07F8 at DONE.

Source files
------------

// File: rtl/frame_loader_sdram.sv
// Streams 8-bit grey pixels into 16-bit SDRAM words for one frame slot.
// Optional oCHECKSUM output is enabled by defining FRAME_LOADER_CHECKSUM_EN.
module frame_loader_sdram #(
    parameter int unsigned H_ACTIVE        = 1024,
    parameter int unsigned V_ACTIVE        = 768,
    parameter int unsigned FRAME_ADDR_BITS = 19
) (
    input  logic        iCLK,
    input  logic        iRST_N,
    input  logic        iSTART,
    input  logic        iABORT,
    input  logic [5:0]  iFRAME_ID,
    input  logic [7:0]  iPIX_DATA,
    input  logic        iPIX_VALID,
    output logic        oPIX_READY,
    input  logic        iWAIT_REQUEST,
    output logic        oWR_EN,
    output logic [24:0] oWR_ADDR,
    output logic [15:0] oWR_DATA,
    output logic        oBUSY,
    output logic        oDONE
`ifdef FRAME_LOADER_CHECKSUM_EN
    ,
    output logic [15:0] oCHECKSUM
`endif
);

    localparam int unsigned ADDR_W      = 25;
    localparam int unsigned DATA_W      = 16;
    localparam int unsigned ID_W        = 6;
    localparam int unsigned FRAME_WORDS = H_ACTIVE * V_ACTIVE / 2;
    localparam logic [FRAME_ADDR_BITS-1:0] LAST_WORD = FRAME_ADDR_BITS'(FRAME_WORDS - 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_FILL  = 2'd1;
    localparam logic [1:0] ST_WRITE = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    logic [1:0]                 state;
    logic [1:0]                 state_d;
    logic [ID_W-1:0]            frame_id_q;
    logic [FRAME_ADDR_BITS-1:0] word_count;
    logic                       pair_hi;
    logic                       start_acc;
    logic                       pix_acc;
    logic                       wr_acc;
    logic                       abort_acc;
    logic                       last_word_c;

    // Saturating at the slot end keeps writes inside the slot even if the frame is oversized.
    assign last_word_c = (word_count == LAST_WORD) || (&word_count);

    // Next-state and handshake decode
    always_comb begin
        state_d   = state;
        start_acc = 1'b0;
        pix_acc   = 1'b0;
        wr_acc    = 1'b0;
        abort_acc = 1'b0;
        case (state)
            ST_IDLE, ST_DONE: begin
                if (iSTART && !iABORT) begin
                    start_acc = 1'b1;
                    state_d   = ST_FILL;
                end
            end
            ST_FILL: begin
                if (iABORT) begin
                    abort_acc = 1'b1;
                    state_d   = ST_IDLE;
                end else if (iPIX_VALID && oPIX_READY) begin
                    pix_acc = 1'b1;
                    if (pair_hi) begin
                        state_d = ST_WRITE;
                    end
                end
            end
            ST_WRITE: begin
                if (iABORT) begin
                    abort_acc = 1'b1;
                    state_d   = ST_IDLE;
                end else if (!iWAIT_REQUEST) begin
                    wr_acc  = 1'b1;
                    state_d = last_word_c ? ST_DONE : ST_FILL;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State, datapath and registered outputs
    always_ff @(posedge iCLK) begin
        if (!iRST_N) begin
            state      <= ST_IDLE;
            frame_id_q <= '0;
            word_count <= '0;
            pair_hi    <= 1'b0;
            oPIX_READY <= 1'b0;
            oWR_EN     <= 1'b0;
            oWR_ADDR   <= '0;
            oWR_DATA   <= '0;
            oBUSY      <= 1'b0;
            oDONE      <= 1'b0;
        end else begin
            state      <= state_d;
            oPIX_READY <= (state_d == ST_FILL);
            oWR_EN     <= (state_d == ST_WRITE);
            oBUSY      <= (state_d == ST_FILL) || (state_d == ST_WRITE);
            oDONE      <= (state_d == ST_DONE);

            if (start_acc) begin
                frame_id_q <= iFRAME_ID;
                word_count <= '0;
                pair_hi    <= 1'b0;
            end

            if (abort_acc) begin
                pair_hi <= 1'b0;
            end

            if (pix_acc) begin
                pair_hi <= ~pair_hi;
                if (!pair_hi) begin
                    oWR_DATA[7:0] <= iPIX_DATA;
                end else begin
                    oWR_DATA[15:8] <= iPIX_DATA;
                    oWR_ADDR       <= ADDR_W'({frame_id_q, word_count});
                end
            end

            if (wr_acc) begin
                word_count <= word_count + FRAME_ADDR_BITS'(1);
            end
        end
    end

`ifdef FRAME_LOADER_CHECKSUM_EN
    // Running byte sum; no pixels are accepted in DONE, so it freezes there.
    always_ff @(posedge iCLK) begin
        if (!iRST_N) begin
            oCHECKSUM <= '0;
        end else if (start_acc) begin
            oCHECKSUM <= '0;
        end else if (pix_acc) begin
            oCHECKSUM <= oCHECKSUM + DATA_W'(iPIX_DATA);
        end
    end
`endif

endmodule
